// File: rtl/predictor_table_ctrl_if.sv
// Port bundle between the predictor controller and its 1R1W branch-history RAM.
// Read data returns the cycle after tbl_rd_en; a same-cycle write is not visible to that read.
interface predictor_table_ctrl_if #(
    parameter int IDX_W = 9
);
    logic             tbl_rd_en;
    logic [IDX_W-1:0] tbl_rd_idx;
    logic [1:0]       tbl_rd_data;
    logic             tbl_wr_en;
    logic [IDX_W-1:0] tbl_wr_idx;
    logic [1:0]       tbl_wr_data;

    modport master (
        output tbl_rd_en, tbl_rd_idx, tbl_wr_en, tbl_wr_idx, tbl_wr_data,
        input  tbl_rd_data
    );

    modport slave (
        input  tbl_rd_en, tbl_rd_idx, tbl_wr_en, tbl_wr_idx, tbl_wr_data,
        output tbl_rd_data
    );
endinterface

// File: rtl/predictor_table_ctrl.sv
// Branch-history table sequencer: init sweep, lookup/update read arbitration, saturating RMW with forwarding.
// Lookup answers 1 cycle after acceptance; busy when FIFO full or stalled, ROB held off while full or initialising.
module predictor_table_ctrl #(
    parameter int         PREDICTOR_SIZE = 512,
    parameter int         IDX_W          = 9,
    parameter int         UPD_DEPTH      = 4,
    parameter logic [1:0] INIT_VAL       = 2'b01
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   lookup_valid_from_fetcher,
    input  logic [31:0]            pc_from_fetcher,
    output logic                   busy_to_fetcher,
    output logic                   predict_valid_to_fetcher,
    output logic                   jump_predict_flag_to_fetcher,
    input  logic                   enable_from_reorderbuffer,
    input  logic [31:0]            inst_addr_from_reorderbuffer,
    input  logic                   jump_result_from_reorderbuffer,
    output logic                   full_to_reorderbuffer,
    predictor_table_ctrl_if.master tbl,
    output logic                   init_done
);
    localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int CNT_W = $clog2(UPD_DEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic             init_done_q, init_done_d;
    upd_t             fifo_q [UPD_DEPTH];
    upd_t             fifo_d [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             upd_pend_q, upd_pend_d;
    upd_t             upd_q, upd_d;
    logic             pv_q, pv_d;
    logic             fwd_hit_q, fwd_hit_d;
    logic [1:0]       fwd_val_q, fwd_val_d;

    logic             fifo_full, push, pop, rd_en, wr_en;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [1:0]       wr_data, fwd_data, upd_new;
    upd_t             head;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{pc_from_fetcher[31:IDX_W], inst_addr_from_reorderbuffer[31:IDX_W]};

    assign fifo_full = (count_q == CNT_W'(UPD_DEPTH));
    assign head      = fifo_q[rd_ptr_q];
    // The RAM returns the pre-write value when read and write collide, so patch it here.
    assign fwd_data  = fwd_hit_q ? fwd_val_q : tbl.tbl_rd_data;

    always_comb begin
        upd_new = fwd_data;
        if (upd_q.taken && fwd_data != 2'b11) begin
            upd_new = fwd_data + 2'b01;
        end else if (!upd_q.taken && fwd_data != 2'b00) begin
            upd_new = fwd_data - 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        upd_pend_d  = 1'b0;
        upd_d       = upd_q;
        pv_d        = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = '0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_data     = '0;
        busy_to_fetcher       = 1'b1;
        full_to_reorderbuffer = 1'b1;
        push        = 1'b0;
        pop         = 1'b0;

        if (state_q == ST_INIT) begin
            // rst_in gates the sweep write so nothing reaches the RAM while reset is held.
            if (rdy_in && rst_in) begin
                wr_en      = 1'b1;
                wr_idx     = init_cnt_q;
                wr_data    = INIT_VAL;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(PREDICTOR_SIZE - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
        end else begin
            full_to_reorderbuffer = fifo_full;
            busy_to_fetcher       = fifo_full || !rdy_in;
            if (upd_pend_q) begin
                wr_en   = 1'b1;
                wr_idx  = upd_q.idx;
                wr_data = upd_new;
            end
            if (rdy_in) begin
                if (fifo_full || (!lookup_valid_from_fetcher && count_q != '0)) begin
                    rd_en      = 1'b1;
                    rd_idx     = head.idx;
                    pop        = 1'b1;
                    upd_pend_d = 1'b1;
                    upd_d      = head;
                end else if (lookup_valid_from_fetcher) begin
                    rd_en  = 1'b1;
                    rd_idx = pc_from_fetcher[IDX_W-1:0];
                    pv_d   = 1'b1;
                end
                push = enable_from_reorderbuffer && !fifo_full;
            end
        end

        if (push) begin
            fifo_d[wr_ptr_q] = '{idx: inst_addr_from_reorderbuffer[IDX_W-1:0],
                                 taken: jump_result_from_reorderbuffer};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        fwd_hit_d = rd_en && wr_en && (rd_idx == wr_idx);
        fwd_val_d = wr_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            for (int i = 0; i < UPD_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            upd_pend_q  <= 1'b0;
            upd_q       <= '0;
            pv_q        <= 1'b0;
            fwd_hit_q   <= 1'b0;
            fwd_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            upd_pend_q  <= upd_pend_d;
            upd_q       <= upd_d;
            pv_q        <= pv_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_val_q   <= fwd_val_d;
        end
    end

    assign tbl.tbl_rd_en   = rd_en;
    assign tbl.tbl_rd_idx  = rd_idx;
    assign tbl.tbl_wr_en   = wr_en;
    assign tbl.tbl_wr_idx  = wr_idx;
    assign tbl.tbl_wr_data = wr_data;

    assign predict_valid_to_fetcher     = pv_q;
    assign jump_predict_flag_to_fetcher = pv_q & fwd_data[1];
    assign init_done                    = init_done_q;
endmodule

// File: tb/tb_predictor_table_ctrl.sv
// Directed bench for predictor_table_ctrl with a behavioural 1R1W RAM (old data on collision).
module tb_predictor_table_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        lk = 1'b0, en = 1'b0, tk = 1'b0;
    logic [31:0] pc = '0, addr = '0;
    logic        busy, pv, flag, full, init_done;
    logic [1:0]  ram [512];
    int          errors = 0;
    int          checks = 0;

    predictor_table_ctrl_if #(.IDX_W(9)) tbl_if ();

    predictor_table_ctrl dut (
        .clk_in                         (clk_in),
        .rst_in                         (rst_in),
        .rdy_in                         (rdy_in),
        .lookup_valid_from_fetcher      (lk),
        .pc_from_fetcher                (pc),
        .busy_to_fetcher                (busy),
        .predict_valid_to_fetcher       (pv),
        .jump_predict_flag_to_fetcher   (flag),
        .enable_from_reorderbuffer      (en),
        .inst_addr_from_reorderbuffer   (addr),
        .jump_result_from_reorderbuffer (tk),
        .full_to_reorderbuffer          (full),
        .tbl                            (tbl_if),
        .init_done                      (init_done)
    );

    always #5 clk_in = ~clk_in;

    // Seeded with 11 so the init sweep's 01 pattern is observable.
    initial for (int i = 0; i < 512; i++) ram[i] = 2'b11;

    always @(posedge clk_in) begin
        if (tbl_if.tbl_rd_en) tbl_if.tbl_rd_data <= ram[tbl_if.tbl_rd_idx];
        if (tbl_if.tbl_wr_en) ram[tbl_if.tbl_wr_idx] <= tbl_if.tbl_wr_data;
    end

    typedef struct {
        logic lk; logic [31:0] pc; logic en; logic [31:0] addr; logic tk; logic rdy;
        logic busy; logic full; logic rd_en; logic [8:0] rd_idx;
        logic wr_en; logic [8:0] wr_idx; logic [1:0] wr_data; logic pv; logic flag;
    } vec_t;

    vec_t vecs [37];

    function automatic vec_t mk(int l, int p, int e, int a, int t, int r,
                                int b, int f, int re, int ri, int we, int wi, int wd, int v, int fl);
        vec_t x;
        x.lk = 1'(l); x.pc = 32'(p); x.en = 1'(e); x.addr = 32'(a); x.tk = 1'(t); x.rdy = 1'(r);
        x.busy = 1'(b); x.full = 1'(f); x.rd_en = 1'(re); x.rd_idx = 9'(ri);
        x.wr_en = 1'(we); x.wr_idx = 9'(wi); x.wr_data = 2'(wd); x.pv = 1'(v); x.flag = 1'(fl);
        return x;
    endfunction

    // Packed view: {busy, full, rd_en, rd_idx, wr_en, wr_idx, wr_data, pv, flag}
    function automatic logic [31:0] outs();
        return {6'b0, busy, full, tbl_if.tbl_rd_en, tbl_if.tbl_rd_idx, tbl_if.tbl_wr_en,
                tbl_if.tbl_wr_idx, tbl_if.tbl_wr_data, pv, flag};
    endfunction

    function automatic logic [31:0] exp_of(vec_t v);
        return {6'b0, v.busy, v.full, v.rd_en, v.rd_idx, v.wr_en, v.wr_idx, v.wr_data, v.pv, v.flag};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic run_init(input int stall_at);
        int wrote = 0;
        lk = 1'b0; en = 1'b0; tk = 1'b0; pc = '0; addr = '0;
        for (int cyc = 0; wrote < 512 && cyc < 600; cyc++) begin
            @(negedge clk_in);
            rst_in = 1'b1;
            rdy_in = (cyc != stall_at);
            #1;
            if (rdy_in) begin
                chk($sformatf("init_write[%0d]", wrote), outs(),
                    {6'b0, 1'b1, 1'b1, 1'b0, 9'd0, 1'b1, 9'(wrote), 2'b01, 1'b0, 1'b0});
                chk("init_done_low", {31'b0, init_done}, 32'd0);
                wrote++;
            end else begin
                chk("init_stall", outs(), {6'b0, 1'b1, 1'b1, 24'b0});
            end
        end
        chk("init_write_count", wrote, 512);
        @(negedge clk_in);
        rdy_in = 1'b1;
        #1;
        chk("init_done_high", {31'b0, init_done}, 32'd1);
        chk("run_first_idle", outs(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(1,'h104,0,0,0,1,   0,0,1,'h104,0,0,0,0,0);
        vecs[1]  = mk(0,0,0,0,0,1,       0,0,0,0,0,0,0,1,0);
        vecs[2]  = mk(0,0,1,'h20,1,1,    0,0,0,0,0,0,0,0,0);
        vecs[3]  = mk(0,0,1,'h20,1,1,    0,0,1,'h20,0,0,0,0,0);
        vecs[4]  = mk(0,0,1,'h20,1,1,    0,0,1,'h20,1,'h20,2,0,0);
        vecs[5]  = mk(0,0,0,0,0,1,       0,0,1,'h20,1,'h20,3,0,0);
        vecs[6]  = mk(1,'h20,0,0,0,1,    0,0,1,'h20,1,'h20,3,0,0);
        vecs[7]  = mk(0,0,0,0,0,1,       0,0,0,0,0,0,0,1,1);
        vecs[8]  = mk(0,0,1,'h20,0,1,    0,0,0,0,0,0,0,0,0);
        vecs[9]  = mk(0,0,1,'h20,0,1,    0,0,1,'h20,0,0,0,0,0);
        vecs[10] = mk(0,0,1,'h20,0,1,    0,0,1,'h20,1,'h20,2,0,0);
        vecs[11] = mk(0,0,1,'h20,0,1,    0,0,1,'h20,1,'h20,1,0,0);
        vecs[12] = mk(0,0,0,0,0,1,       0,0,1,'h20,1,'h20,0,0,0);
        vecs[13] = mk(0,0,0,0,0,1,       0,0,0,0,1,'h20,0,0,0);
        vecs[14] = mk(0,0,0,0,0,1,       0,0,0,0,0,0,0,0,0);
        vecs[15] = mk(0,0,1,5,1,1,       0,0,0,0,0,0,0,0,0);
        vecs[16] = mk(0,0,1,5,1,1,       0,0,1,5,0,0,0,0,0);
        vecs[17] = mk(0,0,0,0,0,1,       0,0,1,5,1,5,2,0,0);
        vecs[18] = mk(1,5,0,0,0,1,       0,0,1,5,1,5,3,0,0);
        vecs[19] = mk(0,0,0,0,0,1,       0,0,0,0,0,0,0,1,1);
        vecs[20] = mk(1,'h40,1,'h30,1,1, 0,0,1,'h40,0,0,0,0,0);
        vecs[21] = mk(1,'h40,1,'h31,1,1, 0,0,1,'h40,0,0,0,1,0);
        vecs[22] = mk(1,'h40,1,'h32,1,1, 0,0,1,'h40,0,0,0,1,0);
        vecs[23] = mk(1,'h40,1,'h33,1,1, 0,0,1,'h40,0,0,0,1,0);
        vecs[24] = mk(1,'h40,1,'h34,1,1, 1,1,1,'h30,0,0,0,1,0);
        vecs[25] = mk(1,'h40,1,'h34,1,1, 0,0,1,'h40,1,'h30,2,0,0);
        vecs[26] = mk(1,'h40,0,0,0,1,    1,1,1,'h31,0,0,0,1,0);
        vecs[27] = mk(1,'h40,0,0,0,1,    0,0,1,'h40,1,'h31,2,0,0);
        vecs[28] = mk(0,0,0,0,0,1,       0,0,1,'h32,0,0,0,1,0);
        vecs[29] = mk(0,0,0,0,0,1,       0,0,1,'h33,1,'h32,2,0,0);
        vecs[30] = mk(0,0,0,0,0,1,       0,0,1,'h34,1,'h33,2,0,0);
        vecs[31] = mk(0,0,0,0,0,1,       0,0,0,0,1,'h34,2,0,0);
        vecs[32] = mk(0,0,0,0,0,1,       0,0,0,0,0,0,0,0,0);
        vecs[33] = mk(0,0,1,'h50,1,1,    0,0,0,0,0,0,0,0,0);
        vecs[34] = mk(0,0,0,0,0,1,       0,0,1,'h50,0,0,0,0,0);
        vecs[35] = mk(1,'h60,1,'h51,1,0, 1,0,0,0,1,'h50,2,0,0);
        vecs[36] = mk(0,0,0,0,0,1,       0,0,0,0,0,0,0,0,0);

        // Reset with requests asserted: everything must stay quiet.
        lk = 1'b1; en = 1'b1; pc = 32'h104; addr = 32'h20;
        repeat (3) @(negedge clk_in);
        #1;
        chk("reset_outs", outs(), {6'b0, 1'b1, 1'b1, 24'b0});
        chk("reset_init_done", {31'b0, init_done}, 32'd0);

        run_init(100);

        for (int i = 0; i < 37; i++) begin
            @(negedge clk_in);
            lk = vecs[i].lk; pc = vecs[i].pc; en = vecs[i].en;
            addr = vecs[i].addr; tk = vecs[i].tk; rdy_in = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d {busy,full,rd_en,rd_idx,wr_en,wr_idx,wr_data,pv,flag}", i),
                outs(), exp_of(vecs[i]));
        end

        // Async reset between an update read and its write; one entry left queued.
        @(negedge clk_in);
        lk = 1'b1; pc = 32'h40; en = 1'b1; addr = 32'h70; tk = 1'b1; rdy_in = 1'b1;
        #1;
        chk("arst_a", outs(), {6'b0, 1'b0, 1'b0, 1'b1, 9'h40, 1'b0, 9'd0, 2'b0, 1'b0, 1'b0});
        @(negedge clk_in);
        addr = 32'h71;
        #1;
        chk("arst_b", outs(), {6'b0, 1'b0, 1'b0, 1'b1, 9'h40, 1'b0, 9'd0, 2'b0, 1'b1, 1'b0});
        @(negedge clk_in);
        lk = 1'b0; en = 1'b0;
        #1;
        chk("arst_c", outs(), {6'b0, 1'b0, 1'b0, 1'b1, 9'h70, 1'b0, 9'd0, 2'b0, 1'b1, 1'b0});
        @(posedge clk_in);
        #1;
        chk("arst_wr_pending", {31'b0, tbl_if.tbl_wr_en}, 32'd1);
        rst_in = 1'b0;
        #1;
        chk("arst_outs", outs(), {6'b0, 1'b1, 1'b1, 24'b0});
        chk("arst_init_done", {31'b0, init_done}, 32'd0);
        repeat (2) @(negedge clk_in);

        run_init(-1);

        // Index 5 held 11 before the re-sweep; it must now read 01.
        @(negedge clk_in);
        lk = 1'b1; pc = 32'h5;
        #1;
        chk("post_lookup_rd", outs(), {6'b0, 1'b0, 1'b0, 1'b1, 9'h5, 1'b0, 9'd0, 2'b0, 1'b0, 1'b0});
        @(negedge clk_in);
        lk = 1'b0;
        #1;
        chk("post_lookup_pred", outs(), {6'b0, 1'b0, 1'b0, 24'b10});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/predictor_table_ctrl.md
Name: predictor_table_ctrl

Overview:
- Scheduler and sequencer for the 2-bit branch-history table, which is held in an external synchronous RAM with one read port and one write port.
- Runs an init sweep after reset, then shares the single read port between fetcher lookups and reorder-buffer update read-modify-writes (RMWs).
- Buffers ROB branch results in a small FIFO.
- Applies saturating counter updates and forwards in-flight writes so that reads are never stale.

Parameters:
- PREDICTOR_SIZE, 512, number of table entries.
- IDX_W, 9, index width; IDX_W = log2(PREDICTOR_SIZE).
- UPD_DEPTH, 4, update FIFO depth (power of two).
- INIT_VAL, 2'b01, counter value written to every entry by the init sweep.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; 0 = stall.
- lookup_valid_from_fetcher  in  1  fetcher requests a prediction.
- pc_from_fetcher  in  32  lookup PC; index = pc[IDX_W-1:0].
- busy_to_fetcher  out  1  lookup not accepted this cycle.
- predict_valid_to_fetcher  out  1  prediction valid (1 cycle after acceptance).
- jump_predict_flag_to_fetcher  out  1  counter[1] of the looked-up entry.
- enable_from_reorderbuffer  in  1  branch result push.
- inst_addr_from_reorderbuffer  in  32  branch PC; index = addr[IDX_W-1:0].
- jump_result_from_reorderbuffer  in  1  1 = taken.
- full_to_reorderbuffer  out  1  FIFO full or init in progress; push refused.
- tbl_rd_en  out  1  RAM read enable.
- tbl_rd_idx  out  IDX_W  RAM read index.
- tbl_rd_data  in  2  RAM read data; valid in the cycle after tbl_rd_en.
- tbl_wr_en  out  1  RAM write enable.
- tbl_wr_idx  out  IDX_W  RAM write index.
- tbl_wr_data  out  2  RAM write data.
- init_done  out  1  table initialised.

Behaviour:
- Reset (rst_in=0, async):
  - State goes to INIT and the init counter is cleared; FIFO and all in-flight tags are emptied.
  - Output reset values: busy_to_fetcher=1, full_to_reorderbuffer=1, predict_valid_to_fetcher=0, jump_predict_flag_to_fetcher=0, tbl_rd_en=0, tbl_wr_en=0, init_done=0, all indices 0, tbl_wr_data=0.
  - Reset asserted mid-operation discards all state and restarts INIT.
- INIT state:
  - Each cycle with rdy_in=1: tbl_wr_en=1, tbl_wr_idx=cnt, tbl_wr_data=INIT_VAL, then cnt++.
  - No reads are issued; busy_to_fetcher=1 and full_to_reorderbuffer=1.
  - After writing index PREDICTOR_SIZE-1, the next state is RUN and init_done is set to 1 (registered).
  - The sweep takes exactly PREDICTOR_SIZE ready cycles.
- RUN state, read-port arbitration (evaluated only when rdy_in=1), highest priority first:
  - (a) FIFO full: issue an update read for the FIFO head; busy_to_fetcher=1.
  - (b) lookup_valid_from_fetcher: issue a lookup read; busy_to_fetcher=0.
  - (c) FIFO non-empty: issue an update read for the head; the head is popped at issue.
  - (d) otherwise: tbl_rd_en=0.
- busy_to_fetcher is combinational in RUN; it is 1 exactly in case (a) or when rdy_in=0.
- Lookup path:
  - A lookup accepted in cycle N gives predict_valid_to_fetcher=1 in cycle N+1.
  - In that cycle, jump_predict_flag_to_fetcher = fwd_data[1].
- Update path:
  - An update read issued in cycle N completes in cycle N+1.
  - In N+1 the block asserts tbl_wr_en=1 with the same index and new = (taken && fwd<3) ? fwd+1 : (!taken && fwd>0) ? fwd-1 : fwd.
  - Counters saturate at 0 and 3 and never wrap.
  - The N+1 write is unconditional, even if rdy_in drops in that cycle.
- Forwarding:
  - fwd_data = tbl_rd_data, except when the write issued in cycle N targets the same index as the read issued in cycle N.
  - In that case fwd_data = that cycle-N write data, because the RAM returns the old value on same-cycle read/write.
  - This allows back-to-back updates to one index at 1 per cycle with correct cumulative results.
- FIFO:
  - A push occurs when enable_from_reorderbuffer=1, full_to_reorderbuffer=0 and rdy_in=1.
  - A push while full is dropped; the ROB must hold the request.
  - full_to_reorderbuffer = count==UPD_DEPTH, or state INIT.
  - The full flag is registered-count based, so a pop in the same cycle does not admit a push into a full FIFO.
  - Push and pop in the same cycle keep the count unchanged. Pointers wrap modulo UPD_DEPTH.
- rdy_in=0: no new reads, no pushes and no init writes are issued; the in-flight completion (N+1) still finishes.

Test Plan:
- Init sweep: release reset, rdy_in=1 → 512 writes, idx 0..511, data 01; init_done rises at cycle 512; full and busy stay 1 until then.
- Lookup after init: lookup pc=0x104 → rd_idx=0x104, next cycle predict_valid=1, flag=0.
- Saturation: push taken×3 to addr 0x20, then a lookup → written values 10, 11, 11; flag=1. Then push not-taken×4 → 10, 01, 00, 00.
- Back-to-back forwarding: two consecutive taken updates to idx 5 from 01 → writes 10 then 11 (not 10 twice). A lookup of idx 5 issued in the same cycle as the second write → flag=1.
- Arbitration/full: fill FIFO (4 pushes) while lookup_valid is held → busy_to_fetcher=1 and updates drain. The 5th push while full is refused; full drops only after a pop registers.
- Async reset mid-RMW: assert rst_in=0 between read and write → tbl_wr_en=0 immediately, FIFO empty, INIT restarts from idx 0.
